// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   CPU-side initiator for the 256x8 data memory read/write/busy_wait
//   handshake. It accepts one load or store per request and drives the memory
//   strobes, address and write data. It holds the CPU with stall until the
//   memory releases busy, then returns the loaded byte on a registered output.
//
// Optional feature (compile-time macro MEM_TIMEOUT_EN):
//   When defined, an 8-bit wait counter aborts an access that is still busy
//   after MAX_WAIT ACCESS cycles. The abort raises err and still pulses done.
//   When undefined, ACCESS waits indefinitely for mem_busy to fall.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   cpu_read   in   load request (level, sampled in IDLE)
//   cpu_write  in   store request (level, sampled in IDLE)
//   cpu_addr   in   request address
//   cpu_wdata  in   store data
//   cpu_rdata  out  loaded byte, registered
//   stall      out  hold the CPU pipeline (combinational)
//   done       out  one-cycle completion pulse
//   err        out  sticky error flag (illegal request or timeout)
//   mem_read   out  read strobe to memory
//   mem_write  out  write strobe to memory
//   mem_addr   out  registered address to memory
//   mem_wdata  out  registered write data to memory
//   mem_rdata  in   read data from memory
//   mem_busy   in   memory busy_wait
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              op_read_reg, op_read_next;
  logic              first_reg, first_next;       // first ACCESS cycle marker
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
  logic              err_reg, err_next;

  logic req_one;
  logic req_both;

  assign req_one  = cpu_read ^ cpu_write;
  assign req_both = cpu_read & cpu_write;

`ifdef MEM_TIMEOUT_EN
  // Counter holds (ACCESS cycles completed so far); on the MAX_WAIT-th ACCESS
  // cycle it reads MAX_WAIT-1, which is when a still-busy access is aborted.
  localparam logic [7:0] MAX_WAIT_M1 = 8'(MAX_WAIT - 1);
  logic [7:0] wait_cnt_reg, wait_cnt_next;
`else
  logic unused_max_wait;
  assign unused_max_wait = |MAX_WAIT;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      op_read_reg   <= 1'b0;
      first_reg     <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cpu_rdata_reg <= '0;
      err_reg       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      op_read_reg   <= op_read_next;
      first_reg     <= first_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      cpu_rdata_reg <= cpu_rdata_next;
      err_reg       <= err_next;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_reg  <= wait_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_read_next   = op_read_reg;
    first_next     = first_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    cpu_rdata_next = cpu_rdata_reg;
    err_next       = err_reg;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_next  = wait_cnt_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (req_one) begin
          mem_addr_next  = cpu_addr;
          mem_wdata_next = cpu_wdata;
          op_read_next   = cpu_read;
          first_next     = 1'b1;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_next  = '0;
`endif
          state_next     = S_ACCESS;
        end else if (req_both) begin
          err_next = 1'b1;
        end
      end

      S_ACCESS: begin
        first_next = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg + 8'd1;
`endif
        // The memory may not have raised busy yet in the first cycle, so
        // completion is only honoured from the second cycle onward.
        if (!first_reg && !mem_busy) begin
          if (op_read_reg) begin
            cpu_rdata_next = mem_rdata;
          end
          state_next = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (mem_busy && (wait_cnt_reg == MAX_WAIT_M1)) begin
          err_next   = 1'b1;
          state_next = S_DONE;
        end
`endif
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // drops them immediately.
  assign mem_read  = (state_reg == S_ACCESS) &&  op_read_reg;
  assign mem_write = (state_reg == S_ACCESS) && !op_read_reg;
  assign stall     = ((state_reg == S_IDLE) && req_one) || (state_reg == S_ACCESS);
  assign done      = (state_reg == S_DONE);
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Self-checking bench for mem_access_ctrl. The bench plays both the CPU and
//   the memory. For every transaction it derives the cycle-by-cycle output
//   timeline from the transaction rules: one request cycle, then
//   max(2, busy+1) ACCESS cycles (capped by MAX_WAIT when timeout is built
//   in), then one DONE cycle. A byte-array memory model supplies load data.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int TB_MAX_WAIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_read, cpu_write;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       stall, done, err, mem_read, mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_busy;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(TB_MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_busy  (mem_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int txn_no = 0;

  // Reference model state
  logic [7:0] mem_model [256];
  logic       m_err;
  logic [7:0] m_rdata, m_addr, m_wdata;

  // Expected outputs for the current cycle
  bit         chk_en = 1'b0;
  logic       e_stall, e_done, e_err, e_read, e_write;
  logic [7:0] e_addr, e_wdata, e_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",     32'(stall),     32'(e_stall));
      check("done",      32'(done),      32'(e_done));
      check("err",       32'(err),       32'(e_err));
      check("mem_read",  32'(mem_read),  32'(e_read));
      check("mem_write", 32'(mem_write), 32'(e_write));
      check("mem_addr",  32'(mem_addr),  32'(e_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      check("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic st, input logic dn, input logic rd, input logic wr);
    e_stall = st; e_done = dn; e_read = rd; e_write = wr;
    e_addr = m_addr; e_wdata = m_wdata; e_rdata = m_rdata; e_err = m_err;
  endtask

  // One IDLE cycle; 'both' presents the illegal read+write request.
  task automatic idle_cycle(input bit both);
    cpu_read  = both;
    cpu_write = both;
    cpu_addr  = 8'($urandom);
    cpu_wdata = 8'($urandom);
    mem_busy  = 1'b0;
    mem_rdata = 8'($urandom);
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if (both) m_err = 1'b1;
  endtask

  task automatic do_txn(input bit is_read, input logic [7:0] addr, input logic [7:0] data,
                        input int busy, output int strobe_cycles, output int done_cycles,
                        output logic [7:0] rdata_done);
    int  len;
    bit  tmo;
    strobe_cycles = 0;
    done_cycles   = 0;
    // request cycle (IDLE)
    cpu_read  = is_read;
    cpu_write = !is_read;
    cpu_addr  = addr;
    cpu_wdata = data;
    mem_busy  = 1'b0;
    mem_rdata = 8'($urandom);
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    m_addr  = addr;
    m_wdata = data;
    len = (busy + 1 < 2) ? 2 : busy + 1;
    tmo = 1'b0;
`ifdef MEM_TIMEOUT_EN
    if (busy >= TB_MAX_WAIT) begin
      len = TB_MAX_WAIT;
      tmo = 1'b1;
    end
`endif
    for (int j = 1; j <= len; j++) begin
      strobe_cycles += int'(mem_read | mem_write);
      mem_busy  = (j <= busy);
      mem_rdata = (j > busy && is_read) ? mem_model[addr] : 8'($urandom);
      set_exp(1'b1, 1'b0, is_read, !is_read);
      tick();
    end
    if (tmo)          m_err = 1'b1;
    else if (is_read) m_rdata = mem_model[addr];
    else              mem_model[addr] = data;
    // DONE cycle: a request presented here must be ignored
    done_cycles += int'(done);
    rdata_done = cpu_rdata;
    cpu_read  = 1'($urandom);
    cpu_write = 1'($urandom);
    cpu_addr  = 8'($urandom);
    cpu_wdata = 8'($urandom);
    mem_busy  = 1'b0;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    txn_no++;
    $display("[TB] txn %0d: %s addr=%02h data=%02h busy=%0d access_cycles=%0d timeout=%0d rdata=%02h",
             txn_no, is_read ? "LOAD " : "STORE", addr, is_read ? mem_model[addr] : data,
             busy, len, tmo, rdata_done);
  endtask

  initial begin
    int sc, dc;
    logic [7:0] rd;
    logic [7:0] prev;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
    reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_busy = 1'b0; mem_rdata = '0;
    m_err = 1'b0; m_rdata = '0; m_addr = '0; m_wdata = '0;
    repeat (3) tick();
    // reset values
    check("rst cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("rst done",      32'(done),      32'h0);
    check("rst err",       32'(err),       32'h0);
    check("rst strobes",   32'({mem_read, mem_write}), 32'h0);
    check("rst mem_addr",  32'(mem_addr),  32'h0);
    check("rst mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst stall",     32'(stall),     32'h0);
    reset = 1'b1;
    chk_en = 1'b1;
    idle_cycle(1'b0);

    // 1: store 0xA5 @0x10, busy for 3 cycles
    do_txn(1'b0, 8'h10, 8'hA5, 3, sc, dc, rd);
    check("t1 write cycles", 32'(sc), 32'd4);
    check("t1 done pulses",  32'(dc), 32'd1);
    check("t1 mem_addr",     32'(mem_addr),  32'h10);
    check("t1 mem_wdata",    32'(mem_wdata), 32'hA5);
    check("t1 stall after",  32'(stall),     32'(cpu_read ^ cpu_write));

    // 2: load @0x10 returns 0xA5, busy for 2 cycles
    idle_cycle(1'b0);
    do_txn(1'b1, 8'h10, 8'h00, 2, sc, dc, rd);
    check("t2 read cycles", 32'(sc), 32'd3);
    check("t2 rdata",       32'(rd), 32'hA5);

    // 3: illegal read+write request
    idle_cycle(1'b1);
    check("t3 err set", 32'(err), 32'h1);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    check("t3 err sticky", 32'(err), 32'h1);

    // 4: reset mid-ACCESS on a pending load
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h33;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    m_addr = 8'h33; m_wdata = cpu_wdata;
    mem_busy = 1'b1;
    set_exp(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_en = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("t4 strobes",   32'({mem_read, mem_write}), 32'h0);
    check("t4 cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("t4 err",       32'(err),       32'h0);
    check("t4 done",      32'(done),      32'h0);
    check("t4 mem_addr",  32'(mem_addr),  32'h0);
    cpu_read = 1'b0;
    #1;
    check("t4 stall", 32'(stall), 32'h0);
    tick();
    reset = 1'b1;
    m_err = 1'b0; m_rdata = '0; m_addr = '0; m_wdata = '0;
    chk_en = 1'b1;
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    // 5: back-to-back load @0x01 then store @0x02
    do_txn(1'b1, 8'h01, 8'h00, 1, sc, dc, rd);
    check("t5 load done", 32'(dc), 32'd1);
    do_txn(1'b0, 8'h02, 8'h5C, 0, sc, dc, rd);
    check("t5 store done",   32'(dc), 32'd1);
    check("t5 store cycles", 32'(sc), 32'd2);

    // randomized traffic over a small address window to get read-after-write hits
    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle_cycle(($urandom_range(0, 9) == 0));
      do_txn(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
             int'($urandom_range(0, 6)), sc, dc, rd);
    end

`ifdef MEM_TIMEOUT_EN
    // 6: busy stuck high -> abort after MAX_WAIT ACCESS cycles
    idle_cycle(1'b0);
    prev = cpu_rdata;
    do_txn(1'b1, 8'h20, 8'h00, 50, sc, dc, rd);
    check("t6 strobe cycles", 32'(sc), 32'(TB_MAX_WAIT));
    check("t6 done pulses",   32'(dc), 32'd1);
    check("t6 err",           32'(err), 32'h1);
    check("t6 rdata kept",    32'(rd), 32'(prev));
`else
    prev = 8'h00;
`endif

    idle_cycle(1'b0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
